instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential instruction encoder and program writer: accepts one instruction description per handshake, packs it into the 32-bit word format that the control decoder consumes (Op at [27:26], Funct at [25:20], Rn/Rd/Src2 below), and writes consecutive words into instruction memory. It sits between the test/boot loader and the instruction-memory write port. It is the exact inverse of the decoder's field interpretation for the supported set: ADD/SUB/XOR/NOT data processing, LDR, LDRD and B.

## Interface
- ADDR_W, 6, word-address width of instruction memory (capacity 2^ADDR_W words)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; clears address, count, done, err, full; enters ACCEPT
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- kind  in  3  000 DP-reg, 001 DP-imm, 010 LDR, 011 LDRD, 100 B, others illegal
- alu_op  in  2  00 ADD, 01 SUB, 10 XOR, 11 NOT (DP kinds only)
- set_flags  in  1  S bit (DP kinds only)
- cond  in  4  condition field, copied to [31:28]
- rd, rn, rm  in  4 each  register fields
- imm  in  24  immediate / branch offset
- last  in  1  request is the final instruction of the program
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written since start
- done  out  1  program complete
- err  out  1  sticky: at least one request dropped
- full  out  1  memory capacity reached

## Operation
- States: IDLE, ACCEPT, WRITE, DONE. Reset → IDLE; every output 0.
- IDLE: in_ready=0; start → ACCEPT.
- ACCEPT: in_ready=1; on in_valid&in_ready, register the encoded word and last.
  - Legal request → WRITE.
  - Illegal request → err=1, word dropped, count unchanged; if last → DONE, else stay in ACCEPT.
- WRITE: mem_we=1 for exactly one cycle, with mem_addr=current address and mem_wdata=registered word. On exit, address+1 and count+1.
  - If last, or count reaches 2^ADDR_W, → DONE. In the capacity case, also set full=1.
  - Otherwise → ACCEPT.
- DONE: done=1, in_ready=0; start → ACCEPT (restart at address 0).
- start in any state restarts the sequence. A start that coincides with a handshake in ACCEPT has priority, and the request is not accepted.
- Encoding, with cmd taken from alu_op: 00→0100, 01→0010, 10→0001, 11→1111.
  - DP-reg: {cond,00,0,cmd,S,rn,rd,8'h00,rm}
  - DP-imm: {cond,00,1,cmd,S,rn,rd,4'h0,imm[7:0]}; imm[23:8]≠0 is illegal
  - NOT forces rn=0 in both DP forms.
  - LDR: {cond,01,011001,rn,rd,imm[11:0]}; imm[23:12]≠0 is illegal
  - LDRD: {cond,01,111101,rn,rd,8'h00,rm}
  - B: {cond,10,10,imm[23:0]}
  - set_flags and alu_op are ignored for non-DP kinds.

## Timing
- Handshake at edge k → mem_we=1 during cycle k+1 → in_ready=1 again from k+2. Peak throughput is one word per 2 cycles.
- An illegal request produces no write; in_ready stays 1 on the next cycle.
- count, mem_addr and full update on the edge that ends WRITE. done rises on that same edge.
- Address wraps to 0 after the last location; the FSM is already in DONE with full=1, so no write wraps.
- Reset mid-WRITE: mem_we drops immediately (asynchronous) and no partial write is permitted.

## Test plan
- ADD R1,R2,R3 (kind 000, alu_op 00, cond E, S 0) then SUBS R4,R4,#5 (kind 001, alu_op 01, S 1, last) → words 0xE0821003 at address 0 and 0xE2544005 at address 1; count=2, done=1, err=0.
- NOT R2,R7 with rn=9 (kind 000, alu_op 11) → 0xE1E02007 (rn forced to 0).
- LDR R0,[R5,#8] → 0xE5950008. B with imm 0x00000A, cond E → 0xEA00000A. LDRD rn=1 rd=2 rm=3 → 0xE7D12003.
- kind 101, then DP-imm with imm=0x100, then a legal ADD with last → no write for the first two, err=1, ADD written at address 0, count=1.
- ADDR_W=2 with 5 requests and no last → 4 writes at addresses 0..3, then full=1, done=1, in_ready=0, fifth request never accepted.
- reset asserted during WRITE → mem_we=0 immediately, all outputs 0, state IDLE; later start → first write at address 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder / program writer: packs one instruction request per
// handshake into the decoder's 32-bit word format and writes it to instruction memory.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [1:0]        alu_op,
  input  logic              set_flags,
  input  logic [3:0]        cond,
  input  logic [3:0]        rd,
  input  logic [3:0]        rn,
  input  logic [3:0]        rm,
  input  logic [23:0]       imm,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [2:0] KIND_DP_REG = 3'b000;
  localparam logic [2:0] KIND_DP_IMM = 3'b001;
  localparam logic [2:0] KIND_LDR    = 3'b010;
  localparam logic [2:0] KIND_LDRD   = 3'b011;
  localparam logic [2:0] KIND_B      = 3'b100;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic              take;
  logic              legal_now;
  logic [ADDR_W:0]   count_inc;
  logic [31:0]       word_p0;
  logic              last_p0;

  function automatic logic [3:0] alu_cmd(input logic [1:0] op);
    logic [3:0] cmd;
    case (op)
      2'b00:   cmd = 4'b0100;
      2'b01:   cmd = 4'b0010;
      2'b10:   cmd = 4'b0001;
      default: cmd = 4'b1111;
    endcase
    return cmd;
  endfunction

  // Only the upper immediate bits decide legality; imm_hi is imm[23:8].
  function automatic logic req_legal(input logic [2:0] k, input logic [15:0] imm_hi);
    logic ok;
    case (k)
      KIND_DP_IMM:                  ok = (imm_hi == 16'h0000);
      KIND_LDR:                     ok = (imm_hi[15:4] == 12'h000);
      KIND_DP_REG, KIND_LDRD, KIND_B: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  k,
    input logic [1:0]  op,
    input logic        s,
    input logic [3:0]  c,
    input logic [3:0]  d,
    input logic [3:0]  n,
    input logic [3:0]  m,
    input logic [23:0] im
  );
    logic [3:0]  n_dp;
    logic [31:0] w;
    // NOT has no first operand, so Rn is encoded as zero.
    n_dp = (op == 2'b11) ? 4'h0 : n;
    case (k)
      KIND_DP_REG: w = {c, 2'b00, 1'b0, alu_cmd(op), s, n_dp, d, 8'h00, m};
      KIND_DP_IMM: w = {c, 2'b00, 1'b1, alu_cmd(op), s, n_dp, d, 4'h0, im[7:0]};
      KIND_LDR:    w = {c, 2'b01, 6'b011001, n, d, im[11:0]};
      KIND_LDRD:   w = {c, 2'b01, 6'b111101, n, d, 8'h00, m};
      default:     w = {c, 2'b10, 2'b10, im};
    endcase
    return w;
  endfunction

  // A start pulse overrides a simultaneous handshake.
  assign take      = in_valid && (state == ACCEPT) && !start;
  assign legal_now = req_legal(kind, imm[23:8]);
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = IDLE;
      ACCEPT: begin
        in_ready = 1'b1;
        if (take) begin
          if (legal_now) state_nxt = WRITE;
          else if (last) state_nxt = DONE;
          else           state_nxt = ACCEPT;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = (last_p0 || (count_inc == CAPACITY)) ? DONE : ACCEPT;
      end
      DONE: done = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = ACCEPT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      count    <= '0;
      err      <= 1'b0;
      full     <= 1'b0;
    end else if (start) begin
      mem_addr <= '0;
      count    <= '0;
      err      <= 1'b0;
      full     <= 1'b0;
    end else begin
      if (take && !legal_now) err <= 1'b1;
      if (state == WRITE) begin
        mem_addr <= mem_addr + 1'b1;
        count    <= count_inc;
        if (count_inc == CAPACITY) full <= 1'b1;
      end
    end
  end

  // Stage p0: encoded word held for the single WRITE cycle.
  always_ff @(posedge clk) begin
    if (take) begin
      word_p0 <= encode(kind, alu_op, set_flags, cond, rd, rn, rm, imm);
      last_p0 <= last;
    end
  end

  // Data register is not reset, so the bus is forced to zero outside WRITE.
  assign mem_wdata = mem_we ? word_p0 : 32'h0000_0000;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized
// requests checked against an arithmetic model of the instruction format.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        in_valid;
  logic [2:0]  kind;
  logic [1:0]  alu_op;
  logic        set_flags;
  logic [3:0]  cond, rd, rn, rm;
  logic [23:0] imm;
  logic        last;

  logic        rdy_a, we_a, done_a, err_a, full_a;
  logic [5:0]  addr_a;
  logic [31:0] wdata_a;
  logic [6:0]  count_a;

  logic        rdy_b, we_b, done_b, err_b, full_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int errors = 0;
  int checks = 0;
  int wcnt_a = 0;
  int wcnt_b = 0;
  logic [31:0] got_word;

  instr_encoder #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .kind(kind), .alu_op(alu_op), .set_flags(set_flags), .cond(cond),
    .rd(rd), .rn(rn), .rm(rm), .imm(imm), .last(last),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .count(count_a),
    .done(done_a), .err(err_a), .full(full_a)
  );

  instr_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
    .kind(kind), .alu_op(alu_op), .set_flags(set_flags), .cond(cond),
    .rd(rd), .rn(rn), .rm(rm), .imm(imm), .last(last),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .count(count_b),
    .done(done_b), .err(err_b), .full(full_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we_a) wcnt_a <= wcnt_a + 1;
    if (we_b) wcnt_b <= wcnt_b + 1;
  end

  // Word built from field weights: cond*2^28, op*2^26, funct*2^20, Rn*2^16, Rd*2^12.
  function automatic logic [31:0] model_word(input int k, input int op, input int s,
                                             input int c, input int d, input int n,
                                             input int m, input int unsigned im,
                                             output bit ok);
    int unsigned w, cmd, rn_eff;
    ok = 1'b1;
    w  = c * 32'h1000_0000;
    case (k)
      0, 1: begin
        cmd    = (op == 0) ? 4 : (op == 1) ? 2 : (op == 2) ? 1 : 15;
        rn_eff = (op == 3) ? 0 : n;
        w += (k * 32 + cmd * 2 + s) * 32'h10_0000 + rn_eff * 32'h1_0000 + d * 32'h1000;
        w += (k == 0) ? m : im % 256;
        if (k == 1 && im >= 256) ok = 1'b0;
      end
      2: begin
        w += 32'h0400_0000 + 25 * 32'h10_0000 + n * 32'h1_0000 + d * 32'h1000 + im % 4096;
        ok = (im < 4096);
      end
      3: w += 32'h0400_0000 + 61 * 32'h10_0000 + n * 32'h1_0000 + d * 32'h1000 + m;
      4: w += 32'h0800_0000 + 32'h0200_0000 + im;
      default: ok = 1'b0;
    endcase
    return w;
  endfunction

  task automatic pulse_start(input bit which);
    @(negedge clk);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit which, input int k, input int op, input int s, input int c,
                      input int d, input int n, input int m, input int unsigned im,
                      input bit lst, input int exp_addr);
    int guard;
    bit ok;
    logic [31:0] w;
    int addr_now;
    logic we_now;
    logic [31:0] wd_now;
    w = model_word(k, op, s, c, d, n, m, im, ok);
    @(negedge clk);
    kind = 3'(k); alu_op = 2'(op); set_flags = s[0]; cond = 4'(c);
    rd = 4'(d); rn = 4'(n); rm = 4'(m); imm = 24'(im); last = lst;
    in_valid = 1'b1;
    guard = 0;
    while (!(which ? rdy_b : rdy_a) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: in_ready low for %0d cycles, required 1", guard);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    addr_now = which ? int'(addr_b) : int'(addr_a);
    we_now   = which ? we_b : we_a;
    wd_now   = which ? wdata_b : wdata_a;
    got_word = wd_now;
    checks++;
    if (we_now !== ok) begin
      errors++;
      $display("FAIL write_strobe kind=%0d: mem_we=%b, required %b", k, we_now, ok);
    end
    if (ok) begin
      checks++;
      if (addr_now !== exp_addr || wd_now !== w) begin
        errors++;
        $display("FAIL write_word kind=%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 k, addr_now, wd_now, exp_addr, w);
      end
    end else if (!lst) begin
      checks++;
      if ((which ? rdy_b : rdy_a) !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_illegal: in_ready=%b, required 1", which ? rdy_b : rdy_a);
      end
    end
  endtask

  task automatic wait_done(input bit which);
    int guard = 0;
    while (!(which ? done_b : done_a) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", guard);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] req);
    checks++;
    if (got_word !== req) begin
      errors++;
      $display("FAIL %s: word=%h, required %h", name, got_word, req);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 0; start_b = 0; in_valid = 0;
    kind = 0; alu_op = 0; set_flags = 0; cond = 0; rd = 0; rn = 0; rm = 0; imm = 0; last = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy_a, we_a, addr_a, wdata_a, count_a, done_a, err_a, full_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: rdy=%b we=%b addr=%0d wdata=%h count=%0d done=%b err=%b full=%b, required all 0",
               rdy_a, we_a, addr_a, wdata_a, count_a, done_a, err_a, full_a);
    end
    checks++;
    if ({rdy_b, we_b, addr_b, wdata_b, count_b, done_b, err_b, full_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: rdy=%b we=%b count=%0d done=%b, required all 0",
               rdy_b, we_b, count_b, done_b);
    end
  endtask

  task automatic test_basic;
    pulse_start(0);
    checks++;
    if (rdy_a !== 1'b1 || count_a !== 7'd0) begin
      errors++;
      $display("FAIL start_state: in_ready=%b count=%0d, required 1 and 0", rdy_a, count_a);
    end
    send(0, 0, 0, 0, 14, 1, 2, 3, 0, 0, 0);
    check_word("add_word", 32'hE082_1003);
    send(0, 1, 1, 1, 14, 4, 4, 0, 5, 1, 1);
    check_word("subs_word", 32'hE254_4005);
    wait_done(0);
    checks++;
    if (count_a !== 7'd2 || done_a !== 1'b1 || err_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: count=%0d done=%b err=%b rdy=%b, required 2 1 0 0",
               count_a, done_a, err_a, rdy_a);
    end
  endtask

  task automatic test_vectors;
    pulse_start(0);
    send(0, 0, 3, 0, 14, 2, 9, 7, 0, 0, 0);
    check_word("not_word", 32'hE1E0_2007);
    send(0, 2, 1, 1, 14, 0, 5, 0, 8, 0, 1);
    check_word("ldr_word", 32'hE595_0008);
    send(0, 4, 2, 1, 14, 0, 0, 0, 'h00000A, 0, 2);
    check_word("b_word", 32'hEA00_000A);
    send(0, 3, 0, 0, 14, 2, 1, 3, 0, 1, 3);
    check_word("ldrd_word", 32'hE7D1_2003);
    wait_done(0);
    checks++;
    if (count_a !== 7'd4 || addr_a !== 6'd4) begin
      errors++;
      $display("FAIL vectors_count: count=%0d addr=%0d, required 4 4", count_a, addr_a);
    end
  endtask

  task automatic test_illegal;
    int w0;
    pulse_start(0);
    w0 = wcnt_a;
    send(0, 5, 0, 0, 14, 1, 2, 3, 0, 0, 0);
    send(0, 1, 0, 0, 14, 1, 2, 0, 'h100, 0, 0);
    send(0, 0, 0, 0, 14, 1, 2, 3, 0, 1, 0);
    wait_done(0);
    checks++;
    if (err_a !== 1'b1 || count_a !== 7'd1 || (wcnt_a - w0) !== 1) begin
      errors++;
      $display("FAIL illegal_drop: err=%b count=%0d writes=%0d, required 1 1 1",
               err_a, count_a, wcnt_a - w0);
    end
    pulse_start(0);
    w0 = wcnt_a;
    send(0, 7, 0, 0, 14, 1, 2, 3, 0, 1, 0);
    checks++;
    if (done_a !== 1'b1 || err_a !== 1'b1 || count_a !== 7'd0 || (wcnt_a - w0) !== 0) begin
      errors++;
      $display("FAIL illegal_last: done=%b err=%b count=%0d writes=%0d, required 1 1 0 0",
               done_a, err_a, count_a, wcnt_a - w0);
    end
  endtask

  task automatic test_start_priority;
    pulse_start(0);
    @(negedge clk);
    kind = 0; alu_op = 0; cond = 14; rd = 1; rn = 2; rm = 3; imm = 0; last = 1;
    in_valid = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (we_a !== 1'b0 || rdy_a !== 1'b1 || count_a !== 7'd0) begin
      errors++;
      $display("FAIL start_priority: we=%b rdy=%b count=%0d, required 0 1 0", we_a, rdy_a, count_a);
    end
  endtask

  task automatic test_random;
    int n_req, exp_writes, w0, addr;
    bit exp_err, ok;
    logic [31:0] dummy;
    n_req = 20; exp_writes = 0; exp_err = 0; addr = 0;
    pulse_start(0);
    w0 = wcnt_a;
    for (int i = 0; i < n_req; i++) begin
      int k, sel;
      int unsigned im;
      k   = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      im  = (sel == 0) ? $urandom_range(0, 255) : (sel == 1) ? $urandom_range(0, 4095) :
            (sel == 2) ? ($urandom & 32'h00FF_FFFF) : 0;
      dummy = model_word(k, 0, 0, 0, 0, 0, 0, im, ok);
      send(0, k, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           im, (i == n_req - 1), addr);
      if (ok) begin exp_writes++; addr++; end
      else exp_err = 1'b1;
    end
    wait_done(0);
    checks++;
    if (int'(count_a) !== exp_writes || err_a !== exp_err || (wcnt_a - w0) !== exp_writes) begin
      errors++;
      $display("FAIL random_totals: count=%0d err=%b writes=%0d, required %0d %b %0d",
               count_a, err_a, wcnt_a - w0, exp_writes, exp_err, exp_writes);
    end
  endtask

  task automatic test_capacity;
    int w0;
    pulse_start(1);
    w0 = wcnt_b;
    for (int i = 0; i < 4; i++)
      send(1, 0, $urandom_range(0, 3), 0, 14, i, i + 1, i + 2, 0, 0, i);
    @(negedge clk);
    checks++;
    if (full_b !== 1'b1 || done_b !== 1'b1 || rdy_b !== 1'b0 || count_b !== 3'd4 || addr_b !== 2'd0) begin
      errors++;
      $display("FAIL capacity_state: full=%b done=%b rdy=%b count=%0d addr=%0d, required 1 1 0 4 0",
               full_b, done_b, rdy_b, count_b, addr_b);
    end
    kind = 0; last = 0; in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ((wcnt_b - w0) !== 4 || count_b !== 3'd4) begin
      errors++;
      $display("FAIL capacity_fifth: writes=%0d count=%0d, required 4 4", wcnt_b - w0, count_b);
    end
  endtask

  task automatic test_reset_mid_write;
    pulse_start(0);
    @(negedge clk);
    kind = 0; alu_op = 0; set_flags = 0; cond = 14; rd = 1; rn = 2; rm = 3; imm = 0; last = 1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (we_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_setup: mem_we=%b, required 1", we_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rdy_a, we_a, addr_a, wdata_a, count_a, done_a, err_a, full_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid_write: we=%b rdy=%b addr=%0d wdata=%h count=%0d done=%b, required all 0",
               we_a, rdy_a, addr_a, wdata_a, count_a, done_a);
    end
    @(negedge clk);
    reset = 1'b0;
    pulse_start(0);
    send(0, 0, 0, 0, 14, 1, 2, 3, 0, 1, 0);
    check_word("after_reset_word", 32'hE082_1003);
    wait_done(0);
    checks++;
    if (count_a !== 7'd1) begin
      errors++;
      $display("FAIL after_reset_count: count=%0d, required 1", count_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_illegal();
    test_start_priority();
    test_random();
    test_capacity();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
